// File: rtl/stepper_pkg.sv
// Shared constants and decode helpers for the stepper read-back decoder.
// Read selects, command bit positions and the forward Gray sequence.
package stepper_pkg;

  localparam int PERIOD_W_DEF = 24;

  localparam logic [1:0] SEL_POS    = 2'b00;
  localparam logic [1:0] SEL_PERIOD = 2'b01;
  localparam logic [1:0] SEL_STATUS = 2'b10;
  localparam logic [1:0] SEL_RAW    = 2'b11;

  localparam int CMD_CLR_POS = 0;
  localparam int CMD_CLR_ERR = 1;
  localparam int CMD_SEL_LSB = 2;

  // {a,b} pairs, index 0 in the low bits: 00 -> 10 -> 11 -> 01
  localparam logic [7:0] GRAY_FWD = {2'b01, 2'b11, 2'b10, 2'b00};

  typedef enum logic [1:0] {
    MV_NONE,
    MV_FWD,
    MV_REV,
    MV_BAD
  } move_t;

  function automatic logic [1:0] gray_next(input logic [1:0] ab);
    logic [1:0] nx;
    nx = GRAY_FWD[1:0];
    for (int i = 0; i < 4; i++) begin
      if (GRAY_FWD[2*i +: 2] == ab) begin
        nx = GRAY_FWD[2*((i+1)%4) +: 2];
      end
    end
    return nx;
  endfunction

  function automatic move_t classify(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    move_t mv;
    mv = MV_BAD;
    unique case (1'b1)
      (cur == prev):            mv = MV_NONE;
      (cur == gray_next(prev)): mv = MV_FWD;
      (prev == gray_next(cur)): mv = MV_REV;
      default:                  mv = MV_BAD;
    endcase
    return mv;
  endfunction

endpackage

// File: rtl/stepper_quad_decoder_filter.sv
// Two-flop synchronizer and glitch filter for the encoder pair.
// The filtered pair moves only after FILTER_CYCLES differing edges.
module quad_input_filter
  import stepper_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] raw,
  output logic [1:0] sync,
  output logic [1:0] filt,
  output logic       upd
);

  localparam int CW =
    (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic [1:0]    meta;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 2'b00;
      sync <= 2'b00;
      filt <= 2'b00;
      cnt  <= '0;
      upd  <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      upd  <= 1'b0;
      if (sync != filt) begin
        if (cnt == LAST) begin
          filt <= sync;
          cnt  <= '0;
          upd  <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stepper_quad_decoder.sv
// Quadrature read-back: position, step period and sticky fault status
// exposed through the stepper command/read word interface.
module stepper_quad_decoder
  import stepper_pkg::*;
#(
  parameter int FILTER_CYCLES = 4,
  parameter int PERIOD_W      = PERIOD_W_DEF
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        phase_a,
  input  logic        phase_b,
  input  logic [31:0] data_in,
  input  logic        new_data,
  output logic [31:0] data_out,
  output logic        step_pulse,
  output logic        step_dir,
  output logic        error
);

  localparam logic [PERIOD_W-1:0] P_MAX = '1;

  logic [1:0]          sync;
  logic [1:0]          filt;
  logic                upd;
  logic [1:0]          prev;
  logic                primed;
  logic [31:0]         position;
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] period_cnt;
  logic [7:0]          err_cnt;
  logic [1:0]          sel;
  move_t               mv;
  logic                step;
  logic                clr_pos;
  logic                clr_err;
  logic [31:0]         rd;
  logic                unused_cmd;

  assign unused_cmd = ^data_in[31:4];

  quad_input_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk  (CLK100MHZ),
    .reset(reset),
    .raw  ({phase_a, phase_b}),
    .sync (sync),
    .filt (filt),
    .upd  (upd)
  );

  always_comb begin
    mv = MV_NONE;
    if (upd && primed) begin
      mv = classify(prev, filt);
    end
  end

  assign step    = (mv == MV_FWD) || (mv == MV_REV);
  assign clr_pos = new_data && data_in[CMD_CLR_POS];
  assign clr_err = new_data && data_in[CMD_CLR_ERR];

  always_comb begin
    rd = 32'd0;
    case (sel)
      SEL_POS:    rd = position;
      SEL_PERIOD: rd = 32'(period_reg);
      SEL_STATUS: rd = {16'd0, err_cnt, 5'd0,
                        primed, step_dir, error};
      SEL_RAW:    rd = {28'd0, filt, sync};
      default:    rd = 32'd0;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      prev       <= 2'b00;
      primed     <= 1'b0;
      position   <= 32'd0;
      period_reg <= P_MAX;
      period_cnt <= '0;
      err_cnt    <= 8'd0;
      sel        <= SEL_POS;
      data_out   <= 32'd0;
      step_pulse <= 1'b0;
      step_dir   <= 1'b0;
      error      <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      data_out   <= rd;
      if (upd) begin
        prev   <= filt;
        primed <= 1'b1;
      end
      case (mv)
        MV_FWD: begin
          position   <= position + 32'd1;
          step_pulse <= 1'b1;
          step_dir   <= 1'b1;
        end
        MV_REV: begin
          position   <= position - 32'd1;
          step_pulse <= 1'b1;
          step_dir   <= 1'b0;
        end
        default: ;
      endcase
      if (clr_pos) begin
        position <= 32'd0;
      end
      if (clr_err) begin
        error   <= 1'b0;
        err_cnt <= 8'd0;
      end
      // an illegal jump in the clearing cycle is still recorded
      if (mv == MV_BAD) begin
        error <= 1'b1;
        if (clr_err) begin
          err_cnt <= 8'd1;
        end else if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
      if (step) begin
        period_reg <= period_cnt;
        period_cnt <= {{(PERIOD_W-1){1'b0}}, 1'b1};
      end else if (period_cnt != P_MAX) begin
        period_cnt <= period_cnt + 1'b1;
      end else begin
        period_reg <= P_MAX;
      end
      if (new_data) begin
        sel <= data_in[CMD_SEL_LSB +: 2];
      end
    end
  end

endmodule

// File: tb/tb_stepper_quad_decoder.sv
// Randomized bench for stepper_quad_decoder against a Gray-index model.
// Short period counter keeps the stall case within a few thousand cycles.
module tb_stepper_quad_decoder;

  localparam int F    = 4;
  localparam int PW   = 12;
  localparam int PMAX = (1 << PW) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        phase_a;
  logic        phase_b;
  logic [31:0] data_in;
  logic        new_data;
  logic [31:0] data_out;
  logic        step_pulse;
  logic        step_dir;
  logic        error;

  always #5 clk = ~clk;

  stepper_quad_decoder #(
    .FILTER_CYCLES(F),
    .PERIOD_W(PW)
  ) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .phase_a   (phase_a),
    .phase_b   (phase_b),
    .data_in   (data_in),
    .new_data  (new_data),
    .data_out  (data_out),
    .step_pulse(step_pulse),
    .step_dir  (step_dir),
    .error     (error)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pos;
  logic        m_err;
  logic        m_dir;
  logic        m_primed;
  logic [7:0]  m_ecnt;
  logic [1:0]  m_ab;
  int          m_pulses;
  int          pulses;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gat(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] fwd(input logic [1:0] ab);
    return gat(gidx(ab) + 1);
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] ab);
    return gat(gidx(ab) + 3);
  endfunction

  function automatic logic [31:0] exp_status();
    return {16'd0, m_ecnt, 5'd0, m_primed, m_dir, m_err};
  endfunction

  task automatic model_level(input logic [1:0] ab);
    int d;
    if (ab == m_ab) return;
    if (!m_primed) begin
      m_primed = 1'b1;
    end else begin
      d = (gidx(ab) - gidx(m_ab) + 4) % 4;
      if (d == 1) begin
        m_pos = m_pos + 1;
        m_dir = 1'b1;
        m_pulses++;
      end else if (d == 3) begin
        m_pos = m_pos - 1;
        m_dir = 1'b0;
        m_pulses++;
      end else begin
        m_err = 1'b1;
        if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 1;
      end
    end
    m_ab = ab;
  endtask

  task automatic model_reset();
    m_pos    = 0;
    m_err    = 0;
    m_dir    = 0;
    m_primed = 0;
    m_ecnt   = 0;
    m_ab     = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (step_pulse) pulses++;
  endtask

  task automatic drive(input logic [1:0] ab);
    {phase_a, phase_b} = ab;
  endtask

  task automatic move(input logic [1:0] ab, input int hold);
    drive(ab);
    repeat (hold) tick();
    model_level(ab);
  endtask

  task automatic cmd(input logic [31:0] w);
    new_data = 1'b1;
    data_in  = w;
    tick();
    new_data = 1'b0;
    data_in  = 32'd0;
  endtask

  task automatic rd(input logic [1:0] s, output logic [31:0] v);
    cmd({28'd0, s, 2'b00});
    tick();
    v = data_out;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] v;
    rd(2'b10, v);
    check({tag, "_status"}, v, exp_status());
    rd(2'b00, v);
    check({tag, "_pos"}, v, m_pos);
    check({tag, "_pulses"}, pulses, m_pulses);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] old_pos;
    logic [31:0] d_lag;
    logic [31:0] d_new;
    int          lat;
    int          p0;
    int          r;
    logic        sp;

    reset    = 1'b1;
    phase_a  = 1'b0;
    phase_b  = 1'b0;
    data_in  = 32'd0;
    new_data = 1'b0;
    pulses   = 0;
    m_pulses = 0;
    model_reset();
    repeat (3) tick();
    check("rst_dout", data_out, 32'd0);
    check("rst_pulse", step_pulse, 1'b0);
    check("rst_dir", step_dir, 1'b0);
    check("rst_err", error, 1'b0);
    reset = 1'b0;
    repeat (4) tick();
    rd(2'b01, v);
    check("rst_period", v, 32'(PMAX));
    rd(2'b11, v);
    check("rst_raw", v, 32'd0);
    check_state("rst");

    for (int i = 0; i < 12; i++) move(fwd(m_ab), 20);
    check("fwd_dir", step_dir, 1'b1);
    check("fwd_dout", data_out, m_pos);
    check_state("fwd");

    old_pos = m_pos;
    drive(fwd(m_ab));
    lat = -1;
    d_lag = 32'd0;
    d_new = 32'd0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step_pulse && lat < 0) lat = i;
      if (i == F + 3) d_lag = data_out;
      if (i == F + 4) d_new = data_out;
    end
    model_level(fwd(m_ab));
    check("latency", lat, F + 3);
    check("dout_lag", d_lag, old_pos);
    check("dout_new", d_new, old_pos + 1);

    cmd(32'h1);
    m_pos = 0;
    for (int i = 0; i < 12; i++) move(rev(m_ab), 20);
    check("rev_dout", data_out, 32'hFFFF_FFF4);
    check("rev_dir", step_dir, 1'b0);

    p0 = pulses;
    drive(rev(m_ab));
    repeat (F + 2) tick();
    new_data = 1'b1;
    data_in  = 32'h1;
    tick();
    sp = step_pulse;
    new_data = 1'b0;
    data_in  = 32'd0;
    repeat (10) tick();
    model_level(rev(m_ab));
    m_pos = 0;
    check("clrstep_pulse", sp, 1'b1);
    check("clrstep_count", pulses - p0, 1);
    check_state("clrstep");

    p0 = pulses;
    drive(m_ab ^ 2'b10);
    repeat (3) tick();
    drive(m_ab);
    repeat (12) tick();
    check("glitch3_pulses", pulses - p0, 0);
    rd(2'b11, v);
    check("glitch3_raw", v, {28'd0, m_ab, m_ab});
    check_state("glitch3");
    p0 = pulses;
    v = {30'd0, m_ab ^ 2'b10};
    move(v[1:0], 4);
    move(v[1:0] ^ 2'b10, 16);
    check("glitch4_pulses", pulses - p0, 2);
    check_state("glitch4");

    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        move(fwd(m_ab), $urandom_range(8, 20));
      end else if (r < 8) begin
        move(rev(m_ab), $urandom_range(8, 20));
      end else if (r == 8) begin
        drive(m_ab ^ ($urandom_range(0, 1) ? 2'b10 : 2'b01));
        repeat ($urandom_range(1, F - 1)) tick();
        drive(m_ab);
        repeat (10) tick();
      end else begin
        move(m_ab ^ 2'b11, $urandom_range(8, 20));
      end
      if (it % 15 == 14) check_state("rand");
    end

    cmd(32'h2);
    m_err  = 0;
    m_ecnt = 0;
    move(rev(m_ab), 12);
    old_pos = m_pos;
    move(m_ab ^ 2'b11, 12);
    check("bad_err", error, 1'b1);
    check_state("bad");
    rd(2'b00, v);
    check("bad_pos", v, old_pos);
    cmd(32'h2);
    m_err  = 0;
    m_ecnt = 0;
    rd(2'b10, v);
    check("clrerr_status", v, 32'h0000_0004);

    for (int i = 0; i < 260; i++) move(m_ab ^ 2'b11, 8);
    check_state("sat");
    drive(m_ab ^ 2'b11);
    repeat (F + 2) tick();
    cmd(32'h2);
    repeat (8) tick();
    model_level(m_ab ^ 2'b11);
    m_ecnt = 1;
    m_err  = 1;
    check("clrerr_race", error, 1'b1);
    check_state("clrerr_race");

    cmd(32'h4);
    for (int i = 0; i < 3; i++) move(fwd(m_ab), 1000);
    check("period_1000", data_out, 32'd1000);
    repeat (4200) tick();
    check("period_stall", data_out, 32'(PMAX));
    move(fwd(m_ab), 30);
    check("period_after_stall", data_out, 32'(PMAX));
    move(fwd(m_ab), 30);
    check("period_30", data_out, 32'd30);

    p0 = pulses;
    drive(2'b11);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    repeat (15) tick();
    model_level(2'b11);
    check("rst11_err", error, 1'b0);
    check("rst11_pulses", pulses - p0, 0);
    rd(2'b10, v);
    check("rst11_status", v, 32'h0000_0004);
    check_state("rst11");

    for (int i = 0; i < 5; i++) move(fwd(m_ab), 15);
    check("mid_dir", step_dir, 1'b1);
    drive(fwd(m_ab));
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("mid_dout", data_out, 32'd0);
    check("mid_pulse", step_pulse, 1'b0);
    check("mid_dir0", step_dir, 1'b0);
    check("mid_err", error, 1'b0);
    reset = 1'b0;
    model_reset();
    p0 = pulses;
    repeat (15) tick();
    model_level({phase_a, phase_b});
    check("mid_prime_pulses", pulses - p0, 0);
    check_state("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
